mgmt_rx_frame_buffer: RTL and testbench
=======================================

Name: mgmt_rx_frame_buffer

Overview:
- Single-clock, parametrised frame buffer between the management-port Ethernet RX stream (already synchronised to the system clock) and the QSPI/CPU reader.
- Stores whole frames, rolls back partial or aborted frames, and publishes one length header per committed frame.
- Reader can read word-by-word or discard the rest of the current frame in one cycle.
- Successor to the fixed 32-bit/1024-deep management RX FIFO: configurable width, depth and MTU; adds link-down abort, skip and optional drop statistics.

Parameters:
- DATA_BYTES, 4, bytes per data word (power of 2, 1..8).
- DEPTH, 1024, data words in frame memory (power of 2).
- HDR_DEPTH, 32, header FIFO entries (power of 2).
- MAX_FRAME_BYTES, 1500, longest accepted frame; longer frames are dropped.
- LEN_BITS, 11, header length width; must satisfy 2^LEN_BITS > MAX_FRAME_BYTES.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- link_up  in  1  ingress link state.
- rx_start  in  1  first cycle of a new frame; carries no data.
- rx_data_valid  in  1  rx_data carries a word.
- rx_bytes_valid  in  $clog2(DATA_BYTES)+1  valid bytes in this word (1..DATA_BYTES).
- rx_data  in  DATA_BYTES*8  frame data, first byte in MSBs.
- rx_commit  in  1  frame ended with good FCS.
- rx_drop  in  1  frame ended bad; discard it.
- hdr_valid  out  1  a committed frame header is available.
- hdr_len  out  LEN_BITS  byte length of the head frame.
- hdr_pop  in  1  consume header; that frame becomes current for reading.
- rd_en  in  1  read next word of current frame.
- rd_skip  in  1  discard the unread remainder of current frame.
- rd_valid  out  1  rd_data valid; asserted the cycle after an accepted rd_en.
- rd_data  out  DATA_BYTES*8  read word.
- free_words  out  $clog2(DEPTH)+1  DEPTH minus words held (committed plus tentative).

Behaviour:
- Reset: all pointers 0, hdr_valid 0, hdr_len 0, rd_valid 0, rd_data 0, free_words DEPTH, write FSM IDLE.
- Pointers: wr_ptr (tentative), commit_ptr, rd_ptr; each $clog2(DEPTH)+1 bits with wrap bit. Occupancy is wr_ptr - rd_ptr, modulo arithmetic.
- Write FSM states: IDLE, ACCEPT, DROPPING.
- rx_start in any state:
  - Go to DROPPING if free_words < ceil(MAX_FRAME_BYTES/DATA_BYTES)+1, header FIFO is full, or link_up=0.
  - Otherwise go to ACCEPT with framelen=0.
- ACCEPT, rx_data_valid:
  - Write the word at wr_ptr, wr_ptr+1, framelen += rx_bytes_valid.
  - If free_words==0 or framelen+rx_bytes_valid > MAX_FRAME_BYTES: do not write, set wr_ptr<=commit_ptr, go to DROPPING.
- ACCEPT, rx_commit: commit_ptr<=wr_ptr (including any word written that cycle), push framelen to header FIFO, go to IDLE.
- rx_drop, or link_up falling while in ACCEPT: wr_ptr<=commit_ptr, go to DROPPING.
- DROPPING: ignore data; leave on rx_commit/rx_drop (to IDLE) or on rx_start (re-evaluated as above).
- Simultaneous events:
  - rx_drop and rx_commit together: drop wins.
  - rx_start with rx_commit: commit finalises the old frame first, then start evaluates.
- Committed frames survive link down; only the in-flight frame is lost.
- Header FIFO is first-word fall-through: hdr_valid=!empty and hdr_len=head entry, combinational from FIFO state.
- hdr_pop while !hdr_valid is ignored. On pop: words_left<=ceil(hdr_len/DATA_BYTES), frame_end<=rd_ptr+words_left.
- rd_en with words_left>0: rd_ptr+1, words_left-1, rd_valid next cycle with memory data (1-cycle read latency). With words_left==0 it is ignored and rd_valid stays 0.
- rd_skip: rd_ptr<=frame_end, words_left<=0, no rd_valid. Skip beats rd_en in the same cycle.
- hdr_pop in the same cycle as rd_en/rd_skip: the read/skip applies to the old frame, then the new frame loads.
- hdr_pop while words_left>0 implicitly skips the remainder first.
- free_words updates the cycle after any pointer change.

Optional Feature:
- Macro MGMT_RX_DROP_STATS_EN.
- Defined: adds output drop_count (32 bits, saturating) and input drop_count_clr. Increments once per frame entering DROPPING for any cause; clr has priority over increment; reset value 0.
- Undefined: neither port exists and no counter logic is generated.

Decomposition:
- Package mgmt_rx_pkg: write FSM state enum, and functions words_for_len() (ceil division) and min_free_words() (MTU threshold).
- One sub-module: mgmt_rx_hdr_fifo, a single-clock FWFT FIFO of width LEN_BITS and depth HDR_DEPTH, with full/empty outputs and the same clock/reset.

Test Plan:
- Defaults; 64-byte frame (16 words) then commit -> hdr_valid=1, hdr_len=64. Pop then 16 rd_en -> 16 rd_valid words matching input; free_words returns to 1024.
- 61-byte frame (last word bytes_valid=1) -> hdr_len=61, exactly 16 words readable; 17th rd_en gives no rd_valid.
- 1504-byte frame -> dropped at the word crossing 1500; wr_ptr back to commit_ptr; no header; drop_count=1 with macro defined.
- Frame A committed; frame B 20 words in, then rx_drop or link_up=0 -> only A's header present; free_words=1024-A's words.
- Fill until free_words < 376, then rx_start -> whole frame dropped. Reader skips one frame -> next rx_start accepted.
- Pop 100-byte frame, read 3 words, rd_skip -> next hdr_pop/rd_en returns the first word of the following frame.

Source files
------------

// File: rtl/mgmt_rx_pkg.sv
// rtl/mgmt_rx_pkg.sv - shared types and sizing helpers for the management RX frame buffer
package mgmt_rx_pkg;

  typedef enum logic [1:0] {
    WR_IDLE     = 2'd0,
    WR_ACCEPT   = 2'd1,
    WR_DROPPING = 2'd2
  } wr_state_e;

  // Number of data words needed to hold len_bytes bytes.
  function automatic int words_for_len(input int len_bytes, input int data_bytes);
    return (len_bytes + data_bytes - 1) / data_bytes;
  endfunction

  // Free space required before a new frame is admitted: one full MTU plus one spare word.
  function automatic int min_free_words(input int max_frame_bytes, input int data_bytes);
    return words_for_len(max_frame_bytes, data_bytes) + 1;
  endfunction

endpackage

// File: rtl/mgmt_rx_hdr_fifo.sv
// rtl/mgmt_rx_hdr_fifo.sv - first-word fall-through FIFO holding committed frame lengths
module mgmt_rx_hdr_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             almost_full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [AW:0]      count;

  assign count       = wptr - rptr;
  assign full        = (count == (AW+1)'(DEPTH));
  assign almost_full = (count == (AW+1)'(DEPTH - 1));
  assign empty       = (count == '0);
  // Head entry is visible without a read strobe; an empty FIFO shows zero.
  assign dout        = empty ? '0 : mem[rptr[AW-1:0]];

  // Pointer update; push into a full FIFO and pop from an empty one are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)  wptr <= wptr + (AW+1)'(1);
      if (pop  && !empty) rptr <= rptr + (AW+1)'(1);
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mgmt_rx_frame_buffer.sv
// rtl/mgmt_rx_frame_buffer.sv - whole-frame RX buffer with rollback; MGMT_RX_DROP_STATS_EN adds drop_count
module mgmt_rx_frame_buffer
  import mgmt_rx_pkg::*;
#(
  parameter int DATA_BYTES      = 4,
  parameter int DEPTH           = 1024,
  parameter int HDR_DEPTH       = 32,
  parameter int MAX_FRAME_BYTES = 1500,
  parameter int LEN_BITS        = 11
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          link_up,
  input  logic                          rx_start,
  input  logic                          rx_data_valid,
  input  logic [$clog2(DATA_BYTES):0]   rx_bytes_valid,
  input  logic [DATA_BYTES*8-1:0]       rx_data,
  input  logic                          rx_commit,
  input  logic                          rx_drop,
  output logic                          hdr_valid,
  output logic [LEN_BITS-1:0]           hdr_len,
  input  logic                          hdr_pop,
  input  logic                          rd_en,
  input  logic                          rd_skip,
  output logic                          rd_valid,
  output logic [DATA_BYTES*8-1:0]       rd_data,
  output logic [$clog2(DEPTH):0]        free_words
`ifdef MGMT_RX_DROP_STATS_EN
  ,
  input  logic                          drop_count_clr,
  output logic [31:0]                   drop_count
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int FL_W  = LEN_BITS + 1;
  localparam logic [PTR_W-1:0] MIN_FREE = PTR_W'(min_free_words(MAX_FRAME_BYTES, DATA_BYTES));
  localparam logic [FL_W-1:0]  MAX_LEN  = FL_W'(MAX_FRAME_BYTES);

  logic [DATA_BYTES*8-1:0] mem [DEPTH];

  wr_state_e         state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_d;
  logic [PTR_W-1:0]  commit_ptr, commit_ptr_d;
  logic [LEN_BITS-1:0] framelen, framelen_d;
  logic [FL_W-1:0]   len_sum;
  logic              data_in;
  logic              mem_we;
  logic              hdr_push;
  logic [LEN_BITS-1:0] hdr_din;
  logic              hdr_full, hdr_afull, hdr_empty, hdr_full_eff;

  logic [PTR_W-1:0]  rd_ptr, rd_ptr_d;
  logic [PTR_W-1:0]  words_left, words_left_d;
  logic [PTR_W-1:0]  frame_end, frame_end_d;
  logic [PTR_W-1:0]  new_words;
  logic              do_read, do_pop;

  assign len_sum      = {1'b0, framelen} + FL_W'(rx_bytes_valid);
  assign data_in      = rx_data_valid && !rx_start;
  assign hdr_full_eff = hdr_full || (hdr_push && hdr_afull);

  // Write FSM: abort, then data, then commit, then a new start is evaluated.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr;
    commit_ptr_d = commit_ptr;
    framelen_d   = framelen;
    mem_we       = 1'b0;
    hdr_push     = 1'b0;
    hdr_din      = '0;
    case (state_q)
      WR_ACCEPT: begin
        if (rx_drop || !link_up) begin
          wr_ptr_d = commit_ptr;
          state_d  = WR_DROPPING;
        end else if (data_in && ((free_words == '0) || (len_sum > MAX_LEN))) begin
          wr_ptr_d = commit_ptr;
          state_d  = WR_DROPPING;
        end else begin
          if (data_in) begin
            mem_we     = 1'b1;
            wr_ptr_d   = wr_ptr + PTR_W'(1);
            framelen_d = len_sum[LEN_BITS-1:0];
          end
          if (rx_commit) begin
            commit_ptr_d = wr_ptr_d;
            hdr_push     = 1'b1;
            hdr_din      = framelen_d;
            state_d      = WR_IDLE;
          end
        end
      end
      WR_DROPPING: begin
        if (rx_commit || rx_drop) state_d = WR_IDLE;
      end
      default: ;
    endcase
    if (rx_start) begin
      wr_ptr_d   = commit_ptr_d;
      framelen_d = '0;
      if ((free_words < MIN_FREE) || hdr_full_eff || !link_up) state_d = WR_DROPPING;
      else                                                     state_d = WR_ACCEPT;
    end
  end

  // Write-side state and pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= WR_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      framelen   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr     <= wr_ptr_d;
      commit_ptr <= commit_ptr_d;
      framelen   <= framelen_d;
    end
  end

  // Frame data storage.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr[AW-1:0]] <= rx_data;
  end

  mgmt_rx_hdr_fifo #(
    .WIDTH (LEN_BITS),
    .DEPTH (HDR_DEPTH)
  ) u_hdr_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (hdr_push),
    .din         (hdr_din),
    .pop         (do_pop),
    .dout        (hdr_len),
    .full        (hdr_full),
    .almost_full (hdr_afull),
    .empty       (hdr_empty)
  );

  assign hdr_valid = !hdr_empty;
  assign do_pop    = hdr_pop && hdr_valid;
  assign do_read   = rd_en && !rd_skip && (words_left != '0);
  assign new_words = PTR_W'(words_for_len(int'(hdr_len), DATA_BYTES));

  // Read side: read/skip act on the old frame, then a pop jumps to its end and loads the next one.
  always_comb begin
    rd_ptr_d     = rd_skip ? frame_end : rd_ptr + PTR_W'(do_read);
    words_left_d = rd_skip ? '0 : words_left - PTR_W'(do_read);
    frame_end_d  = frame_end;
    if (do_pop) begin
      rd_ptr_d     = frame_end;
      words_left_d = new_words;
      frame_end_d  = frame_end + new_words;
    end
  end

  // Read-side registers, read data and free-space count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      words_left <= '0;
      frame_end  <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      free_words <= PTR_W'(DEPTH);
    end else begin
      rd_ptr     <= rd_ptr_d;
      words_left <= words_left_d;
      frame_end  <= frame_end_d;
      rd_valid   <= do_read;
      if (do_read) rd_data <= mem[rd_ptr[AW-1:0]];
      free_words <= PTR_W'(DEPTH) - (wr_ptr_d - rd_ptr_d);
    end
  end

`ifdef MGMT_RX_DROP_STATS_EN
  logic drop_evt;
  assign drop_evt = (state_d == WR_DROPPING) && ((state_q != WR_DROPPING) || rx_start);

  // Saturating count of frames discarded during reception; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst_n)                              drop_count <= '0;
    else if (drop_count_clr)                 drop_count <= '0;
    else if (drop_evt && (drop_count != '1)) drop_count <= drop_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mgmt_rx_frame_buffer.sv
// tb/tb_mgmt_rx_frame_buffer.sv - randomized self-checking bench for mgmt_rx_frame_buffer
module tb_mgmt_rx_frame_buffer;

  localparam int DB      = 4;
  localparam int DEPTH   = 1024;
  localparam int HDRD    = 32;
  localparam int MAXB    = 1500;
  localparam int MINFREE = 376;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        link_up = 1'b1;
  logic        rx_start = 1'b0;
  logic        rx_data_valid = 1'b0;
  logic [2:0]  rx_bytes_valid = '0;
  logic [31:0] rx_data = '0;
  logic        rx_commit = 1'b0;
  logic        rx_drop = 1'b0;
  logic        hdr_valid;
  logic [10:0] hdr_len;
  logic        hdr_pop = 1'b0;
  logic        rd_en = 1'b0;
  logic        rd_skip = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [10:0] free_words;
`ifdef MGMT_RX_DROP_STATS_EN
  logic        drop_count_clr = 1'b0;
  logic [31:0] drop_count;
  int          exp_drops = 0;
`endif

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_words[$];
  int          exp_lens[$];
  int          cur_left = 0;

  always #5 clk = ~clk;

  mgmt_rx_frame_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .link_up        (link_up),
    .rx_start       (rx_start),
    .rx_data_valid  (rx_data_valid),
    .rx_bytes_valid (rx_bytes_valid),
    .rx_data        (rx_data),
    .rx_commit      (rx_commit),
    .rx_drop        (rx_drop),
    .hdr_valid      (hdr_valid),
    .hdr_len        (hdr_len),
    .hdr_pop        (hdr_pop),
    .rd_en          (rd_en),
    .rd_skip        (rd_skip),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .free_words     (free_words)
`ifdef MGMT_RX_DROP_STATS_EN
    ,
    .drop_count_clr (drop_count_clr),
    .drop_count     (drop_count)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int model_free();
    return DEPTH - exp_words.size();
  endfunction

  // Send one frame. ending: 0 commit, 1 rx_drop, 2 link loss then a stray commit.
  task automatic send_frame(input int nbytes, input int ending, output bit kept);
    int nw;
    int bv;
    bit ok;
    logic [31:0] w[$];
    nw = (nbytes + DB - 1) / DB;
    ok = (model_free() >= MINFREE) && (exp_lens.size() < HDRD);
    rx_start = 1'b1;
    tick;
    rx_start = 1'b0;
    for (int i = 0; i < nw; i++) begin
      bv = (i == nw - 1) ? nbytes - DB * i : DB;
      rx_data_valid  = 1'b1;
      rx_bytes_valid = 3'(bv);
      rx_data        = $urandom;
      w.push_back(rx_data);
      tick;
    end
    rx_data_valid  = 1'b0;
    rx_bytes_valid = '0;
    case (ending)
      0:       rx_commit = 1'b1;
      1:       rx_drop   = 1'b1;
      default: link_up   = 1'b0;
    endcase
    tick;
    rx_commit = 1'b0;
    rx_drop   = 1'b0;
    if (ending == 2) begin
      link_up   = 1'b1;
      rx_commit = 1'b1;
      tick;
      rx_commit = 1'b0;
    end
    kept = ok && (nbytes <= MAXB) && (ending == 0);
    if (kept) begin
      foreach (w[i]) exp_words.push_back(w[i]);
      exp_lens.push_back(nbytes);
    end
`ifdef MGMT_RX_DROP_STATS_EN
    if (!kept) exp_drops++;
`endif
  endtask

  // Pop the head header, issue nread rd_en cycles, optionally skip the remainder.
  task automatic pop_and_read(input int nread, input bit skip);
    int len;
    logic [31:0] e;
    n_cmp++;
    if (exp_lens.size() == 0) begin
      n_fail++;
      $display("FAIL pop_no_frame: hdr_valid=%0d, bench expected a frame", hdr_valid);
      return;
    end
    if (hdr_valid !== 1'b1 || hdr_len !== 11'(exp_lens[0])) begin
      n_fail++;
      $display("FAIL hdr_head: valid=%0d len=%0d, required valid=1 len=%0d", hdr_valid, hdr_len, exp_lens[0]);
    end
    for (int i = 0; i < cur_left; i++) e = exp_words.pop_front();
    len = exp_lens.pop_front();
    cur_left = (len + DB - 1) / DB;
    hdr_pop = 1'b1;
    tick;
    hdr_pop = 1'b0;
    n_cmp++;
    if (hdr_valid !== (exp_lens.size() > 0)) begin
      n_fail++;
      $display("FAIL hdr_valid_after_pop: got %0d, required %0d", hdr_valid, exp_lens.size() > 0);
    end
    for (int i = 0; i < nread; i++) begin
      rd_en = 1'b1;
      tick;
      n_cmp++;
      if (cur_left > 0) begin
        e = exp_words.pop_front();
        cur_left--;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
          n_fail++;
          $display("FAIL rd_word: valid=%0d data=%h, required valid=1 data=%h", rd_valid, rd_data, e);
        end
      end else if (rd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rd_past_end: rd_valid=%0d, required 0", rd_valid);
      end
    end
    rd_en = 1'b0;
    if (skip) begin
      rd_skip = 1'b1;
      tick;
      rd_skip = 1'b0;
      n_cmp++;
      if (rd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL skip_valid: rd_valid=%0d, required 0", rd_valid);
      end
      for (int i = 0; i < cur_left; i++) e = exp_words.pop_front();
      cur_left = 0;
    end
  endtask

  task automatic test_free(input string tag);
    tick;
    n_cmp++;
    if (free_words !== 11'(model_free())) begin
      n_fail++;
      $display("FAIL free_words_%s: got %0d, required %0d", tag, free_words, model_free());
    end
  endtask

  task automatic drain;
    int w;
    while (exp_lens.size() > 0) begin
      w = (exp_lens[0] + DB - 1) / DB;
      pop_and_read($urandom_range(0, w + 1), 1'($urandom_range(0, 1)));
    end
    if (cur_left > 0) begin
      rd_skip = 1'b1;
      tick;
      rd_skip = 1'b0;
      for (int i = 0; i < cur_left; i++) void'(exp_words.pop_front());
      cur_left = 0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    n_cmp++;
    if (hdr_valid !== 1'b0 || hdr_len !== 11'd0 || rd_valid !== 1'b0 || rd_data !== 32'd0 || free_words !== 11'd1024) begin
      n_fail++;
      $display("FAIL reset: hdr_valid=%0d hdr_len=%0d rd_valid=%0d rd_data=%h free=%0d, required 0 0 0 0 1024",
               hdr_valid, hdr_len, rd_valid, rd_data, free_words);
    end
  endtask

  task automatic test_basic;
    bit kept;
    send_frame(64, 0, kept);
    n_cmp++;
    if (hdr_valid !== 1'b1 || hdr_len !== 11'd64 || free_words !== 11'd1008) begin
      n_fail++;
      $display("FAIL basic_hdr: valid=%0d len=%0d free=%0d, required 1 64 1008", hdr_valid, hdr_len, free_words);
    end
    pop_and_read(17, 1'b0);
    test_free("basic");
  endtask

  task automatic test_short_last;
    bit kept;
    send_frame(61, 0, kept);
    n_cmp++;
    if (hdr_len !== 11'd61) begin
      n_fail++;
      $display("FAIL short_len: got %0d, required 61", hdr_len);
    end
    pop_and_read(17, 1'b0);
    test_free("short");
  endtask

  task automatic test_oversize;
    bit kept;
    send_frame(1504, 0, kept);
    n_cmp++;
    if (hdr_valid !== 1'b0 || free_words !== 11'(model_free())) begin
      n_fail++;
      $display("FAIL oversize: hdr_valid=%0d free=%0d, required 0 %0d", hdr_valid, free_words, model_free());
    end
`ifdef MGMT_RX_DROP_STATS_EN
    n_cmp++;
    if (drop_count !== 32'(exp_drops)) begin
      n_fail++;
      $display("FAIL drop_count_oversize: got %0d, required %0d", drop_count, exp_drops);
    end
`endif
  endtask

  task automatic test_abort;
    bit kept;
    send_frame($urandom_range(1, 400), 0, kept);
    send_frame(80, 1, kept);
    test_free("abort_drop");
    send_frame(80, 2, kept);
    test_free("abort_link");
    n_cmp++;
    if (hdr_valid !== 1'b1 || hdr_len !== 11'(exp_lens[0])) begin
      n_fail++;
      $display("FAIL abort_hdr: valid=%0d len=%0d, required 1 %0d", hdr_valid, hdr_len, exp_lens[0]);
    end
    drain;
    test_free("abort_end");
  endtask

  task automatic test_fill;
    bit kept;
    int guard = 0;
    while (model_free() >= MINFREE && guard < 10) begin
      send_frame($urandom_range(900, 1500), 0, kept);
      guard++;
    end
    send_frame(200, 0, kept);
    test_free("fill_reject");
    pop_and_read(0, 1'b1);
    test_free("fill_skip");
    send_frame(200, 0, kept);
    test_free("fill_accept");
    drain;
    test_free("fill_end");
  endtask

  task automatic test_skip;
    bit kept;
    send_frame(100, 0, kept);
    send_frame($urandom_range(4, 200), 0, kept);
    pop_and_read(3, 1'b1);
    pop_and_read(2, 1'b0);
    drain;
    test_free("skip_end");
  endtask

  task automatic test_hdr_full;
    bit kept;
    for (int i = 0; i < HDRD + 1; i++) send_frame($urandom_range(1, 8), 0, kept);
    test_free("hdr_full");
    drain;
    test_free("hdr_full_end");
  endtask

  task automatic test_random;
    bit kept;
    int r;
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 9);
      send_frame((r == 9) ? $urandom_range(1400, 1600) : $urandom_range(1, 1400),
                 (r < 7) ? 0 : (r == 7 ? 1 : (r == 8 ? 2 : 0)), kept);
      if (exp_lens.size() >= 3 || (exp_lens.size() > 0 && $urandom_range(0, 1) == 1))
        pop_and_read($urandom_range(0, (exp_lens[0] + DB - 1) / DB + 1), 1'($urandom_range(0, 1)));
    end
    drain;
    test_free("random_end");
`ifdef MGMT_RX_DROP_STATS_EN
    n_cmp++;
    if (drop_count !== 32'(exp_drops)) begin
      n_fail++;
      $display("FAIL drop_count_total: got %0d, required %0d", drop_count, exp_drops);
    end
    drop_count_clr = 1'b1;
    tick;
    drop_count_clr = 1'b0;
    exp_drops = 0;
    n_cmp++;
    if (drop_count !== 32'd0) begin
      n_fail++;
      $display("FAIL drop_count_clr: got %0d, required 0", drop_count);
    end
`endif
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_basic;
    test_short_last;
    test_oversize;
    test_abort;
    test_fill;
    test_skip;
    test_hdr_full;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
